// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl
//   Sequencer between the UART byte receiver and the 8-byte word packer.
//   Waits for SYNC_BYTE, forwards the next 8 bytes to the packer, captures
//   the packer's 64-bit word and offers it downstream with valid/ready.
//   Inter-byte or packer stalls abort the frame and flush the packer.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   dato, rx_flat     byte from UART receiver and its 1-cycle strobe
//   pk_dato           registered byte to packer
//   pk_rx_flat        1-cycle strobe to packer
//   pk_rst_n          active-low packer reset (low while flushing)
//   pk_data, pk_flat  assembled word from packer and its strobe
//   word_data         captured word, frozen while word_valid=1
//   word_valid        word offered downstream
//   word_ready        downstream accept
//   busy              FSM not idle
//   err_timeout       1-cycle pulse: frame aborted
//   err_overrun       1-cycle pulse: byte dropped or stray pk_flat
//   drop_cnt          aborted-frame count, saturating at 255
module rx_frame_ctrl #(
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned PK_WAIT_CYC = 4,
    parameter int unsigned FLUSH_CYC   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  dato,
    input  logic        rx_flat,
    output logic [7:0]  pk_dato,
    output logic        pk_rx_flat,
    output logic        pk_rst_n,
    input  logic [63:0] pk_data,
    input  logic        pk_flat,
    output logic [63:0] word_data,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        busy,
    output logic        err_timeout,
    output logic        err_overrun,
    output logic [7:0]  drop_cnt
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC);
    localparam int unsigned PKW_W = $clog2(PK_WAIT_CYC);
    localparam int unsigned FL_W  = $clog2(FLUSH_CYC + 1);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [PKW_W-1:0] PKW_LAST = PKW_W'(PK_WAIT_CYC - 1);
    localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_CYC - 1);

    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_FWD,
        ST_WAIT_PK,
        ST_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [PKW_W-1:0] pkw_q, pkw_d;
    logic [FL_W-1:0]  fl_q, fl_d;

    logic [7:0]  pk_dato_d;
    logic        pk_rx_flat_d;
    logic        pk_rst_n_d;
    logic [63:0] word_data_d;
    logic        word_valid_d;
    logic        err_timeout_d;
    logic        err_overrun_d;
    logic [7:0]  drop_cnt_d;
    logic        abort;

    assign busy = (state_q != ST_IDLE);

    always_comb begin
        state_d       = state_q;
        byte_cnt_d    = byte_cnt_q;
        tmo_d         = tmo_q;
        pkw_d         = pkw_q;
        fl_d          = fl_q;
        pk_dato_d     = pk_dato;
        pk_rx_flat_d  = 1'b0;
        word_data_d   = word_data;
        word_valid_d  = word_valid;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;
        drop_cnt_d    = drop_cnt;
        abort         = 1'b0;

        // A packer word is only expected while waiting for it.
        if (pk_flat && (state_q != ST_WAIT_PK)) begin
            err_overrun_d = 1'b1;
        end

        unique case (state_q)
            ST_FLUSH: begin
                if (fl_q == FL_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    fl_d = fl_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (rx_flat && (dato == SYNC_BYTE)) begin
                    state_d    = ST_FWD;
                    byte_cnt_d = '0;
                    tmo_d      = '0;
                end
            end
            ST_FWD: begin
                if (rx_flat) begin
                    pk_dato_d    = dato;
                    pk_rx_flat_d = 1'b1;
                    byte_cnt_d   = byte_cnt_q + 1'b1;
                    tmo_d        = '0;
                    if (byte_cnt_q == 3'd7) begin
                        state_d = ST_WAIT_PK;
                        pkw_d   = '0;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_WAIT_PK: begin
                if (rx_flat) begin
                    err_overrun_d = 1'b1;
                end
                if (pk_flat) begin
                    word_data_d  = pk_data;
                    word_valid_d = 1'b1;
                    state_d      = ST_HOLD;
                end else if (pkw_q == PKW_LAST) begin
                    abort = 1'b1;
                end else begin
                    pkw_d = pkw_q + 1'b1;
                end
            end
            ST_HOLD: begin
                // A byte arriving in the accept cycle is still dropped.
                if (rx_flat) begin
                    err_overrun_d = 1'b1;
                end
                if (word_ready) begin
                    word_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_FLUSH;
                fl_d    = '0;
            end
        endcase

        if (abort) begin
            state_d       = ST_FLUSH;
            fl_d          = '0;
            err_timeout_d = 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt_d = drop_cnt + 8'd1;
            end
        end

        // Derived from the next state so the packer reset drops on the same
        // edge that enters FLUSH and rises on the edge that leaves it.
        pk_rst_n_d = (state_d != ST_FLUSH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FLUSH;
            byte_cnt_q  <= '0;
            tmo_q       <= '0;
            pkw_q       <= '0;
            fl_q        <= '0;
            pk_dato     <= '0;
            pk_rx_flat  <= 1'b0;
            pk_rst_n    <= 1'b0;
            word_data   <= '0;
            word_valid  <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            tmo_q       <= tmo_d;
            pkw_q       <= pkw_d;
            fl_q        <= fl_d;
            pk_dato     <= pk_dato_d;
            pk_rx_flat  <= pk_rx_flat_d;
            pk_rst_n    <= pk_rst_n_d;
            word_data   <= word_data_d;
            word_valid  <= word_valid_d;
            err_timeout <= err_timeout_d;
            err_overrun <= err_overrun_d;
            drop_cnt    <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb_rx_frame_ctrl
//   Directed-sequence bench for rx_frame_ctrl with random payloads, a
//   behavioural packer stand-in, and pulse/strobe monitors.
`timescale 1ns/1ps
module tb_rx_frame_ctrl;

    localparam logic [7:0]  SYNC = 8'hA5;
    localparam int unsigned TMO  = 1024;
    localparam int unsigned PKW  = 4;
    localparam int unsigned FLC  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  dato;
    logic        rx_flat;
    logic [7:0]  pk_dato;
    logic        pk_rx_flat;
    logic        pk_rst_n;
    logic [63:0] pk_data;
    logic        pk_flat;
    logic [63:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic        busy;
    logic        err_timeout;
    logic        err_overrun;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    rx_frame_ctrl #(
        .SYNC_BYTE  (SYNC),
        .TIMEOUT_CYC(TMO),
        .PK_WAIT_CYC(PKW),
        .FLUSH_CYC  (FLC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dato       (dato),
        .rx_flat    (rx_flat),
        .pk_dato    (pk_dato),
        .pk_rx_flat (pk_rx_flat),
        .pk_rst_n   (pk_rst_n),
        .pk_data    (pk_data),
        .pk_flat    (pk_flat),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun),
        .drop_cnt   (drop_cnt)
    );

    // Packer stand-in: collects forwarded bytes, first byte in the LSBs,
    // and strobes the word one cycle after the 8th byte.
    logic [7:0]  pk_q[$];
    logic        pk_flat_m = 1'b0;
    logic        pk_stray  = 1'b0;
    logic        pk_en     = 1'b1;
    logic [63:0] pk_data_m = '0;
    assign pk_flat = pk_flat_m | pk_stray;
    assign pk_data = pk_data_m;

    always @(posedge clk) begin
        pk_flat_m <= 1'b0;
        pk_data_m <= {$urandom, $urandom};
        if (!pk_rst_n) begin
            pk_q.delete();
        end else if (pk_rx_flat) begin
            pk_q.push_back(pk_dato);
            if (pk_q.size() == 8) begin
                for (int i = 0; i < 8; i++) pk_data_m[8*i +: 8] <= pk_q[i];
                pk_flat_m <= pk_en;
                pk_q.delete();
            end
        end
    end

    // Monitors, sampled on the falling edge.
    int          n_tmo = 0, n_ovr = 0, n_bad = 0, n_unst = 0;
    int          low_run = 0, last_low = 0;
    logic [7:0]  fwd_q[$];
    logic        prev_v = 1'b0;
    logic [63:0] prev_d = '0;

    always @(negedge clk) begin
        if (err_timeout === 1'b1) n_tmo++;
        if (err_overrun === 1'b1) n_ovr++;
        if (pk_rx_flat === 1'b1 && pk_rst_n !== 1'b1) n_bad++;
        if (pk_rx_flat === 1'b1) fwd_q.push_back(pk_dato);
        if (rst) low_run = 0;
        else if (pk_rst_n !== 1'b1) low_run++;
        else begin
            if (low_run != 0) last_low = low_run;
            low_run = 0;
        end
        if (word_valid === 1'b1 && prev_v && word_data !== prev_d) n_unst++;
        prev_v = (word_valid === 1'b1);
        prev_d = word_data;
    end

    int          n_checks = 0, n_pass = 0, n_fail = 0;
    int          exp_drop = 0;
    logic [63:0] last_word;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        dato    = b;
        rx_flat = 1'b1;
        step();
        rx_flat = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] w, input bit gaps);
        send_byte(SYNC);
        for (int i = 0; i < 8; i++) begin
            if (gaps) idle($urandom_range(0, 3));
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic wait_valid(input string tag);
        int unsigned k = 0;
        while (word_valid !== 1'b1 && k < 40) begin
            step();
            k++;
        end
        check(tag, 64'(word_valid), 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int unsigned k = 0;
        while (busy !== 1'b0 && k < 40) begin
            step();
            k++;
        end
        check(tag, 64'(busy), 64'd0);
    endtask

    task automatic accept(input bit with_byte, input logic [7:0] b);
        word_ready = 1'b1;
        if (with_byte) begin
            dato    = b;
            rx_flat = 1'b1;
        end
        step();
        word_ready = 1'b0;
        rx_flat    = 1'b0;
    endtask

    function automatic logic [63:0] fwd_word(input int f0);
        logic [63:0] w = '0;
        for (int i = 0; i < 8; i++) begin
            if (f0 + i < fwd_q.size()) w[8*i +: 8] = fwd_q[f0 + i];
        end
        return w;
    endfunction

    task automatic frame_ok(input logic [63:0] w, input string tag);
        int f0 = fwd_q.size();
        int o0 = n_ovr;
        send_frame(w, 1'b1);
        wait_valid({tag, "_valid"});
        last_word = word_data;
        check({tag, "_word"}, word_data, w);
        check({tag, "_fwd_n"}, 64'(fwd_q.size() - f0), 64'd8);
        check({tag, "_fwd_bytes"}, fwd_word(f0), w);
        accept(1'b0, 8'h00);
        check({tag, "_done"}, {62'd0, word_valid, busy}, 64'd0);
        check({tag, "_no_ovr"}, 64'(n_ovr - o0), 64'd0);
    endtask

    function automatic logic [63:0] rnd_word();
        return {$urandom, $urandom};
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] w;
        logic [7:0]  b;
        int          t0, o0, f0;

        rst        = 1'b1;
        dato       = 8'h00;
        rx_flat    = 1'b0;
        word_ready = 1'b0;
        idle(3);

        // Reset values
        check("rst_pk_rst_n", 64'(pk_rst_n), 64'd0);
        check("rst_pk_out", {55'd0, pk_rx_flat, pk_dato}, 64'd0);
        check("rst_word", {63'd0, word_valid}, 64'd0);
        check("rst_word_data", word_data, 64'd0);
        check("rst_errs_drop", {54'd0, err_timeout, err_overrun, drop_cnt}, 64'd0);
        check("rst_busy", 64'(busy), 64'd1);

        // Power-up flush
        rst = 1'b0;
        step();
        check("pwr_flush1", {62'd0, pk_rst_n, busy}, 64'b01);
        step();
        check("pwr_idle", {62'd0, pk_rst_n, busy}, 64'b10);

        // Non-sync bytes in IDLE are ignored silently
        o0 = n_ovr;
        f0 = fwd_q.size();
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            if (b == SYNC) b = 8'h3C;
            send_byte(b);
            idle($urandom_range(0, 2));
        end
        check("idle_junk", {62'd0, busy, 1'b0}, 64'd0);
        check("idle_junk_quiet", 64'((n_ovr - o0) + (fwd_q.size() - f0)), 64'd0);

        // 1: basic frame
        frame_ok(64'h0807060504030201, "t1");

        // 2: byte timeout after 3 payload bytes
        t0 = n_tmo;
        send_byte(SYNC);
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        idle(TMO - 1);
        check("t2_no_early_tmo", 64'(n_tmo - t0), 64'd0);
        check("t2_busy_waiting", 64'(busy), 64'd1);
        step();
        exp_drop = (exp_drop == 255) ? 255 : exp_drop + 1;
        check("t2_tmo_pulse", {62'd0, err_timeout, pk_rst_n}, 64'b10);
        check("t2_drop", 64'(drop_cnt), 64'(exp_drop));
        step();
        check("t2_flush2", {61'd0, err_timeout, pk_rst_n, busy}, 64'b001);
        step();
        check("t2_idle", {62'd0, pk_rst_n, busy}, 64'b10);
        check("t2_flush_len", 64'(last_low), 64'(FLC));
        frame_ok(rnd_word(), "t2_after");

        // 3: back-pressure with 5 bytes dropped
        w = rnd_word();
        send_frame(w, 1'b1);
        wait_valid("t3_valid");
        o0 = n_ovr;
        f0 = fwd_q.size();
        for (int i = 0; i < 50; i++) begin
            if (i % 10 == 3) send_byte(8'($urandom));
            else step();
        end
        check("t3_still_valid", 64'(word_valid), 64'd1);
        check("t3_word_frozen", word_data, w);
        check("t3_ovr_cnt", 64'(n_ovr - o0), 64'd5);
        check("t3_no_fwd", 64'(fwd_q.size() - f0), 64'd0);
        accept(1'b0, 8'h00);
        check("t3_accepted", {62'd0, word_valid, busy}, 64'd0);

        // Overrun in WAIT_PK and in the accept cycle (sync byte must not start a frame)
        w = rnd_word();
        f0 = fwd_q.size();
        send_frame(w, 1'b0);
        o0 = n_ovr;
        send_byte(8'h5A);
        wait_valid("t3b_valid");
        check("t3b_word", word_data, w);
        accept(1'b1, SYNC);
        idle(2);
        check("t3b_ovr_cnt", 64'(n_ovr - o0), 64'd2);
        check("t3b_idle", {62'd0, word_valid, busy}, 64'd0);
        check("t3b_fwd_n", 64'(fwd_q.size() - f0), 64'd8);

        // Stray pk_flat in IDLE
        o0 = n_ovr;
        pk_stray = 1'b1;
        step();
        pk_stray = 1'b0;
        step();
        check("stray_ovr", 64'(n_ovr - o0), 64'd1);
        check("stray_ignored", {62'd0, word_valid, busy}, 64'd0);

        // 4: sync value inside payload is data
        w = rnd_word();
        w[39:32] = SYNC;
        frame_ok(w, "t4");
        check("t4_byte4", 64'(last_word[39:32]), 64'(SYNC));

        // 5: reset after the 6th payload byte
        send_byte(SYNC);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom));
        rst = 1'b1;
        #1;
        exp_drop = 0;
        check("t5_rst_now", {60'd0, word_valid, pk_rst_n, pk_rx_flat, busy}, 64'b0001);
        step();
        step();
        rst = 1'b0;
        step();
        check("t5_flush1", {62'd0, pk_rst_n, busy}, 64'b01);
        step();
        check("t5_idle", {62'd0, pk_rst_n, busy}, 64'b10);
        check("t5_drop", 64'(drop_cnt), 64'(exp_drop));
        frame_ok(rnd_word(), "t5_after");

        // Reset while holding a word discards it
        send_frame(rnd_word(), 1'b1);
        wait_valid("t5b_valid");
        rst = 1'b1;
        #1;
        check("t5b_discard", {63'd0, word_valid}, 64'd0);
        check("t5b_data_clr", word_data, 64'd0);
        step();
        rst = 1'b0;
        idle(2);
        frame_ok(rnd_word(), "t5b_after");

        // 6: drop_cnt saturation through packer-wait aborts
        pk_en = 1'b0;
        t0 = n_tmo;
        for (int k = 0; k < 260; k++) begin
            send_frame(rnd_word(), 1'b0);
            wait_idle("t6_abort_idle");
            exp_drop = (exp_drop == 255) ? 255 : exp_drop + 1;
            check("t6_drop", 64'(drop_cnt), 64'(exp_drop));
        end
        check("t6_tmo_cnt", 64'(n_tmo - t0), 64'd260);
        check("t6_sat", 64'(drop_cnt), 64'd255);
        check("t6_flush_len", 64'(last_low), 64'(FLC));
        pk_en = 1'b1;
        frame_ok(rnd_word(), "t6_after");
        check("t6_still_sat", 64'(drop_cnt), 64'd255);

        // Global invariants
        check("strobe_in_flush", 64'(n_bad), 64'd0);
        check("hold_unstable", 64'(n_unst), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
